// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM widths, ramp FSM states and prescaler period convention
package pwm_pkg;

  localparam int DEF_DUTY_W = 8;
  localparam int DEF_DIV_W  = 16;

  // A divider value N always means a period of N + PERIOD_ADJ clock cycles.
  localparam int PERIOD_ADJ = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RAMP = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/pwm_tick_div.sv
// rtl/pwm_tick_div.sv - counts 0..div with sync clear, emits a 1-cycle tick on wrap
module pwm_tick_div
  import pwm_pkg::*;
#(
  parameter int W = DEF_DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == div);

  // Free-running count while enabled; wraps to zero on the tick cycle.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_ramp.sv
// rtl/pwm_duty_ramp.sv - slews registered PWM duty toward a handshaked target; DUTY_RAMP_CLAMP_EN adds min/max clamp
module pwm_duty_ramp
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W,
  parameter int DIV_W  = DEF_DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tgt_valid,
  output logic              tgt_ready,
  input  logic [DUTY_W-1:0] tgt_duty,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [DUTY_W-1:0] step_size,
`ifdef DUTY_RAMP_CLAMP_EN
  input  logic [DUTY_W-1:0] duty_min,
  input  logic [DUTY_W-1:0] duty_max,
`endif
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done
);

  ramp_state_t       state;
  logic [DUTY_W-1:0] tgt_q;
  logic [DUTY_W-1:0] step_q;
  logic [DIV_W-1:0]  div_q;
  logic              dir_up;

  logic              xfer;
  logic              tick;
  logic [DUTY_W-1:0] tgt_eff;
  logic [DUTY_W-1:0] step_eff;
  logic [DUTY_W:0]   diff;
  logic              last_step;

  assign busy      = (state != IDLE);
  assign tgt_ready = (state != LOAD);
  assign xfer      = tgt_valid && tgt_ready;

  // A zero step would stall the ramp forever, so it is promoted to one.
  assign step_eff  = (step_q == '0) ? DUTY_W'(1) : step_q;

  // Distance to target, one bit wider so the subtraction never wraps.
  assign diff      = dir_up ? ({1'b0, tgt_q} - {1'b0, duty})
                            : ({1'b0, duty} - {1'b0, tgt_q});
  assign last_step = (diff <= {1'b0, step_eff});

  // Target seen by LOAD: optionally clamped, max bound applied last so it wins on inverted bounds.
  always_comb begin
    tgt_eff = tgt_q;
`ifdef DUTY_RAMP_CLAMP_EN
    if (tgt_eff < duty_min) tgt_eff = duty_min;
    if (tgt_eff > duty_max) tgt_eff = duty_max;
`endif
  end

  pwm_tick_div #(
    .W(DIV_W)
  ) u_tick_div (
    .clk (clk),
    .rst (rst),
    .clr (state == LOAD),
    .en  (state == RAMP),
    .div (div_q),
    .tick(tick)
  );

  // Ramp FSM: accept target, decide direction in LOAD, step toward target on each tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      duty   <= '0;
      done   <= 1'b0;
      dir_up <= 1'b0;
      tgt_q  <= '0;
      step_q <= '0;
      div_q  <= '0;
    end else begin
      done <= 1'b0;
      if (xfer) begin
        // A new target always wins; any step coinciding with it is dropped.
        tgt_q  <= tgt_duty;
        step_q <= step_size;
        div_q  <= step_div;
        state  <= LOAD;
      end else begin
        case (state)
          LOAD: begin
            tgt_q  <= tgt_eff;
            dir_up <= (tgt_eff > duty);
            if (tgt_eff == duty) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= RAMP;
            end
          end
          RAMP: begin
            if (tick) begin
              if (last_step) begin
                duty  <= tgt_q;
                done  <= 1'b1;
                state <= IDLE;
              end else if (dir_up) begin
                duty <= duty + step_eff;
              end else begin
                duty <= duty - step_eff;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// tb/tb_pwm_duty_ramp.sv - table-driven and scoreboard bench for pwm_duty_ramp
module tb_pwm_duty_ramp;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tgt_valid = 1'b0;
  logic        tgt_ready;
  logic [7:0]  tgt_duty = '0;
  logic [15:0] step_div = '0;
  logic [7:0]  step_size = '0;
  logic [7:0]  duty_min = 8'd0;
  logic [7:0]  duty_max = 8'd255;
  logic [7:0]  duty;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pwm_duty_ramp dut (
    .clk      (clk),
    .rst      (rst),
    .tgt_valid(tgt_valid),
    .tgt_ready(tgt_ready),
    .tgt_duty (tgt_duty),
    .step_div (step_div),
    .step_size(step_size),
`ifdef DUTY_RAMP_CLAMP_EN
    .duty_min (duty_min),
    .duty_max (duty_max),
`endif
    .duty     (duty),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic [7:0]  tgt;
    logic [7:0]  step;
    logic [15:0] div;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  exp_clamp;
    logic [7:0]  exp_plain;
  } vec_t;

  typedef struct {
    int duty;
    int period;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];
  int   n_pass  = 0;
  int   n_total = 0;
  int   mdl_duty = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Offer one target from IDLE; returns #1 after the transfer edge.
  task automatic drive(input logic [7:0] t, input logic [7:0] s, input logic [15:0] d,
                       input logic [7:0] lo, input logic [7:0] hi);
    @(negedge clk);
    chk("ready_before_xfer", int'(tgt_ready), 1);
    tgt_duty  = t;
    step_size = s;
    step_div  = d;
    duty_min  = lo;
    duty_max  = hi;
    tgt_valid = 1'b1;
    @(posedge clk);
    #1 tgt_valid = 1'b0;
  endtask

  // Build expected duty trace from mdl_duty, then watch the DUT against it.
  task automatic collect(input logic [7:0] t, input logic [7:0] s, input logic [15:0] d,
                         input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] exp_final);
    int tq, cur, es, per, done_per, bound, prev, dcnt, done_seen;
    exp_t e;
    tq = int'(t);
`ifdef DUTY_RAMP_CLAMP_EN
    if (tq < int'(lo)) tq = int'(lo);
    if (tq > int'(hi)) tq = int'(hi);
`endif
    es = (s == 8'd0) ? 1 : int'(s);
    cur = mdl_duty;
    per = int'(d) + 2;
    done_per = 1;
    while (cur != tq) begin
      if (tq > cur) cur = (tq - cur <= es) ? tq : cur + es;
      else          cur = (cur - tq <= es) ? tq : cur - es;
      e.duty = cur;
      e.period = per;
      sb.push_back(e);
      done_per = per;
      per += int'(d) + 1;
    end
    bound = (sb.size() + 2) * (int'(d) + 1) + 6;
    prev = mdl_duty;
    dcnt = 0;
    done_seen = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("load_busy", int'(busy), 1);
        chk("load_ready", int'(tgt_ready), 0);
      end
      if (k == 1) chk("ready_after_load", int'(tgt_ready), 1);
      if (int'(duty) != prev) begin
        if (sb.size() == 0) begin
          chk("unexpected_duty_change", int'(duty), prev);
        end else begin
          e = sb.pop_front();
          chk("step_duty", int'(duty), e.duty);
          chk("step_time", k, e.period);
        end
        prev = int'(duty);
      end
      if (done_seen >= 0 && k == done_seen + 1) begin
        chk("done_one_cycle", int'(done), 0);
        chk("idle_busy", int'(busy), 0);
        chk("idle_ready", int'(tgt_ready), 1);
        break;
      end
      if (done === 1'b1) begin
        dcnt++;
        chk("done_time", k, done_per);
        chk("done_duty", int'(duty), int'(exp_final));
        if (done_seen < 0) done_seen = k;
      end
    end
    chk("done_count", dcnt, 1);
    chk("sb_empty", sb.size(), 0);
    chk("final_duty", int'(duty), int'(exp_final));
    sb.delete();
    mdl_duty = int'(exp_final);
  endtask

  initial begin
    int   found, dcnt;
    logic [7:0] ef;

    vecs[0] = '{8'd100, 8'd10,  16'd0, 8'd0,  8'd255, 8'd100, 8'd100};
    vecs[1] = '{8'd5,   8'd10,  16'd3, 8'd0,  8'd255, 8'd5,   8'd5};
    vecs[2] = '{8'd5,   8'd7,   16'd1, 8'd0,  8'd255, 8'd5,   8'd5};
    vecs[3] = '{8'd0,   8'd0,   16'd0, 8'd0,  8'd255, 8'd0,   8'd0};
    vecs[4] = '{8'd255, 8'd255, 16'd1, 8'd0,  8'd255, 8'd255, 8'd255};
    vecs[5] = '{8'd250, 8'd100, 16'd0, 8'd20, 8'd200, 8'd200, 8'd250};
    vecs[6] = '{8'd5,   8'd60,  16'd0, 8'd20, 8'd200, 8'd20,  8'd5};
    vecs[7] = '{8'd128, 8'd3,   16'd2, 8'd0,  8'd255, 8'd128, 8'd128};
    vecs[8] = '{8'd128, 8'd9,   16'd0, 8'd0,  8'd255, 8'd128, 8'd128};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_duty", int'(duty), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(tgt_ready), 1);
    chk("rst_done", int'(done), 0);
    mdl_duty = 0;

    for (int i = 0; i < 9; i++) begin
`ifdef DUTY_RAMP_CLAMP_EN
      ef = vecs[i].exp_clamp;
`else
      ef = vecs[i].exp_plain;
`endif
      drive(vecs[i].tgt, vecs[i].step, vecs[i].div, vecs[i].lo, vecs[i].hi);
      collect(vecs[i].tgt, vecs[i].step, vecs[i].div, vecs[i].lo, vecs[i].hi, ef);
    end

    // Retarget mid-ramp, coincident with a step tick.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mdl_duty = 0;
    drive(8'd200, 8'd1, 16'd0, 8'd0, 8'd255);
    found = 0;
    dcnt = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1) dcnt++;
      if (duty == 8'd50) begin
        found = 1;
        tgt_duty  = 8'd20;
        step_size = 8'd1;
        step_div  = 16'd0;
        tgt_valid = 1'b1;
        break;
      end
    end
    chk("retarget_reached_50", found, 1);
    chk("retarget_no_early_done", dcnt, 0);
    if (found == 1) begin
      @(posedge clk);
      #1 tgt_valid = 1'b0;
      mdl_duty = 50;
      collect(8'd20, 8'd1, 16'd0, 8'd0, 8'd255, 8'd20);
    end
    tgt_valid = 1'b0;

    // Reset in the middle of a slow ramp abandons it.
    drive(8'd200, 8'd1, 16'd5, 8'd0, 8'd255);
    repeat (30) @(negedge clk);
    chk("midramp_busy", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(tgt_ready), 1);
    chk("midrst_done", int'(done), 0);
    mdl_duty = 0;
    drive(8'd3, 8'd1, 16'd0, 8'd0, 8'd255);
    collect(8'd3, 8'd1, 16'd0, 8'd0, 8'd255, 8'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
